// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a fetch/decode boundary carrying PC, PC+4 and
// the instruction word. A main entry always drives the outputs. A skid entry
// catches one extra payload so that in_ready can come straight from a flop.
// Flush and reset both leave a bubble (NOP) in the held entries.
module pipe_skid_reg #(
    parameter int                   PC_W      = 20,
    parameter int                   INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
    parameter bit                   SKID_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_pcplus4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pcplus4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy,
    output logic [15:0]        flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // The counter sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        flush_cnt_q;

    logic [PC_W-1:0]    main_pc_p0, main_pcplus4_p0;
    logic [INSTR_W-1:0] main_instr_p0;
    logic [PC_W-1:0]    skid_pc_p1, skid_pcplus4_p1;
    logic [INSTR_W-1:0] skid_instr_p1;
    logic               vld_p0, vld_p1;

    logic accept, release_x;
    logic load_bubble, load_main_in, load_main_skid, load_skid_in;

    assign vld_p0    = (state_q != ST_EMPTY);
    assign vld_p1    = (state_q == ST_FULL);
    assign out_valid = vld_p0;
    assign occupancy = vld_p1 ? 2'd2 : (vld_p0 ? 2'd1 : 2'd0);
    assign flush_cnt = flush_cnt_q;

    // With the skid entry the ready depends only on registered state.
    // Without it, ready has to look at out_ready, and FULL is never reached.
    assign in_ready  = SKID_EN ? (state_q != ST_FULL) : (!vld_p0 || out_ready);

    assign accept    = in_valid && in_ready;
    assign release_x = vld_p0 && out_ready;

    // Next-state and entry-load selection; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_bubble    = 1'b0;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d     = ST_EMPTY;
            load_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_HALF;
                        load_main_in = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept && release_x) begin
                        load_main_in = 1'b1;
                    end else if (accept && SKID_EN) begin
                        state_d      = ST_FULL;
                        load_skid_in = 1'b1;
                    end else if (release_x) begin
                        state_d     = ST_EMPTY;
                        load_bubble = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (release_x) begin
                        state_d        = ST_HALF;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    load_bubble = 1'b1;
                end
            endcase
        end
    end

    // State register and saturating count of flushes that discarded something.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (flush && vld_p0)
                flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    // ---- p0: main entry (drives the outputs) / p1: skid entry ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_pc_p0      <= '0;
            main_pcplus4_p0 <= '0;
            main_instr_p0   <= NOP_INSTR;
            skid_pc_p1      <= '0;
            skid_pcplus4_p1 <= '0;
            skid_instr_p1   <= NOP_INSTR;
        end else begin
            if (load_bubble) begin
                main_pc_p0      <= '0;
                main_pcplus4_p0 <= '0;
                main_instr_p0   <= NOP_INSTR;
                skid_pc_p1      <= '0;
                skid_pcplus4_p1 <= '0;
                skid_instr_p1   <= NOP_INSTR;
            end else begin
                if (load_main_in) begin
                    main_pc_p0      <= in_pc;
                    main_pcplus4_p0 <= in_pcplus4;
                    main_instr_p0   <= in_instr;
                end else if (load_main_skid) begin
                    main_pc_p0      <= skid_pc_p1;
                    main_pcplus4_p0 <= skid_pcplus4_p1;
                    main_instr_p0   <= skid_instr_p1;
                end
                if (load_skid_in) begin
                    skid_pc_p1      <= in_pc;
                    skid_pcplus4_p1 <= in_pcplus4;
                    skid_instr_p1   <= in_instr;
                end
            end
        end
    end

    assign out_pc      = main_pc_p0;
    assign out_pcplus4 = main_pcplus4_p0;
    assign out_instr   = main_instr_p0;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: one instance with the skid entry, one
// without. Inputs change on the falling edge; outputs are checked there too.
module tb_pipe_skid_reg;

    localparam int PC_W    = 20;
    localparam int INSTR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic               in_valid, in_ready, flush, out_valid, out_ready;
    logic [PC_W-1:0]    in_pc, in_pcplus4, out_pc, out_pcplus4;
    logic [INSTR_W-1:0] in_instr, out_instr;
    logic [1:0]         occupancy;
    logic [15:0]        flush_cnt;

    logic               s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
    logic [PC_W-1:0]    s0_in_pc, s0_in_pcplus4, s0_out_pc, s0_out_pcplus4;
    logic [INSTR_W-1:0] s0_in_instr, s0_out_instr;
    logic [1:0]         s0_occupancy;
    logic [15:0]        s0_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .SKID_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_instr(out_instr),
        .occupancy(occupancy), .flush_cnt(flush_cnt)
    );

    pipe_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_pc(s0_in_pc), .in_pcplus4(s0_in_pcplus4), .in_instr(s0_in_instr),
        .flush(s0_flush),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_pc(s0_out_pc), .out_pcplus4(s0_out_pcplus4), .out_instr(s0_out_instr),
        .occupancy(s0_occupancy), .flush_cnt(s0_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [19:0] pc, input logic [31:0] ins);
        in_valid   = v;
        in_pc      = pc;
        in_pcplus4 = pc + 20'd4;
        in_instr   = ins;
    endtask

    task automatic drive0(input logic v, input logic [19:0] pc, input logic [31:0] ins);
        s0_in_valid   = v;
        s0_in_pc      = pc;
        s0_in_pcplus4 = pc + 20'd4;
        s0_in_instr   = ins;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One accept into an empty stage followed by a flush.
    task automatic fill_and_flush();
        drive(1'b1, 20'h00abc, 32'h1111_0000);
        step();
        drive(1'b0, 20'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        drive(1'b0, 20'h0, 32'h0);
        drive0(1'b0, 20'h0, 32'h0);
        flush = 1'b0; out_ready = 1'b0;
        s0_flush = 1'b0; s0_out_ready = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_instr", 32'(out_instr), NOP);
        reset = 1'b0;

        // Single transfer
        out_ready = 1'b1;
        drive(1'b1, 20'h00100, 32'h0050_0093);
        step();
        chk("single_valid",   32'(out_valid),   32'd1);
        chk("single_pc",      32'(out_pc),      32'h00100);
        chk("single_pcplus4", 32'(out_pcplus4), 32'h00104);
        chk("single_instr",   32'(out_instr),   32'h0050_0093);
        drive(1'b0, 20'h0, 32'h0);
        step();
        chk("single_drain_valid", 32'(out_valid), 32'd0);
        chk("single_drain_instr", 32'(out_instr), NOP);
        chk("single_drain_pc",    32'(out_pc),    32'h0);

        // Back-pressure: A, idle hold, B, then drain in order
        out_ready = 1'b0;
        drive(1'b1, 20'h00200, 32'h0000_000a);
        step();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        drive(1'b0, 20'h0, 32'h0);
        step();
        chk("bp_hold_pc",  32'(out_pc),    32'h00200);
        chk("bp_hold_occ", 32'(occupancy), 32'd1);
        drive(1'b1, 20'h00300, 32'h0000_000b);
        step();
        chk("bp_occ2",     32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_out_a",    32'(out_pc),    32'h00200);
        chk("bp_instr_a",  32'(out_instr), 32'h0000_000a);
        drive(1'b0, 20'h0, 32'h0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b",     32'(out_pc),      32'h00300);
        chk("bp_pc4_b",     32'(out_pcplus4), 32'h00304);
        chk("bp_occ_after", 32'(occupancy),   32'd1);
        chk("bp_ready_aft", 32'(in_ready),    32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming one per cycle
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 20'(i * 16), 32'(i));
            step();
            chk("stream_pc",  32'(out_pc),    32'(i * 16));
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        drive(1'b0, 20'h0, 32'h0);
        step();
        chk("stream_end", 32'(out_valid), 32'd0);

        // Flush while FULL with a simultaneous offer
        out_ready = 1'b0;
        drive(1'b1, 20'h00400, 32'h0000_0041); step();
        drive(1'b1, 20'h00500, 32'h0000_0051); step();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 20'h00600, 32'h0000_0061);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 20'h0, 32'h0);
        chk("fl_occ",   32'(occupancy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_instr", 32'(out_instr), NOP);
        chk("fl_cnt",   32'(flush_cnt), 32'd1);
        step();
        chk("fl_not_held", 32'(out_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_empty_cnt", 32'(flush_cnt), 32'd1);

        // Reset between edges while FULL
        drive(1'b1, 20'h00700, 32'h0000_0071); step();
        drive(1'b1, 20'h00800, 32'h0000_0081); step();
        drive(1'b0, 20'h0, 32'h0);
        chk("mr_pre_occ", 32'(occupancy), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_occ",   32'(occupancy), 32'd0);
        chk("mr_cnt",   32'(flush_cnt), 32'd0);
        chk("mr_ready", 32'(in_ready),  32'd1);
        step();
        reset = 1'b0;
        drive(1'b1, 20'h00900, 32'h0000_0091);
        step();
        drive(1'b0, 20'h0, 32'h0);
        chk("mr_first_pc",  32'(out_pc),    32'h00900);
        chk("mr_first_occ", 32'(occupancy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush counting from HALF, then saturation near the top
        for (int i = 0; i < 3; i++) fill_and_flush();
        chk("sat_cnt3", 32'(flush_cnt), 32'd3);
        force dut.flush_cnt_q = 16'hFFFC;
        #1 release dut.flush_cnt_q;
        step();
        chk("sat_preload", 32'(flush_cnt), 32'h0000_FFFC);
        for (int i = 0; i < 2; i++) fill_and_flush();
        chk("sat_fffe", 32'(flush_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) fill_and_flush();
        chk("sat_ffff", 32'(flush_cnt), 32'h0000_FFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_empty_hold", 32'(flush_cnt), 32'h0000_FFFF);

        // Single-entry variant
        s0_out_ready = 1'b0;
        drive0(1'b1, 20'h00a00, 32'h0000_00a1);
        step();
        drive0(1'b1, 20'h00b00, 32'h0000_00b1);
        #1;
        chk("s0_valid",     32'(s0_out_valid), 32'd1);
        chk("s0_ready_low", 32'(s0_in_ready),  32'd0);
        step();
        chk("s0_occ",   32'(s0_occupancy), 32'd1);
        chk("s0_hold",  32'(s0_out_pc),    32'h00a00);
        s0_out_ready = 1'b1;
        #1;
        chk("s0_ready_same", 32'(s0_in_ready), 32'd1);
        step();
        chk("s0_b",     32'(s0_out_pc),    32'h00b00);
        chk("s0_occ_b", 32'(s0_occupancy), 32'd1);
        drive0(1'b1, 20'h00c00, 32'h0000_00c1);
        step();
        chk("s0_c", 32'(s0_out_pc), 32'h00c00);
        drive0(1'b0, 20'h0, 32'h0);
        step();
        chk("s0_drain", 32'(s0_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL provide parameter PC_W, default 20, width of PC and PC+4 fields.
REQ-002 SHALL provide parameter INSTR_W, default 32, width of instruction field.
REQ-003 SHALL provide parameter NOP_INSTR, default 32'h0000_0013, bubble instruction inserted on flush or drain.
REQ-004 SHALL provide parameter SKID_EN, default 1, 1 = two-entry skid buffer, 0 = single-entry register.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept payload.
- in_pc  in  PC_W  upstream PC.
- in_pcplus4  in  PC_W  upstream PC+4.
- in_instr  in  INSTR_W  upstream instruction.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts payload.
- out_pc  out  PC_W  held PC.
- out_pcplus4  out  PC_W  held PC+4.
- out_instr  out  INSTR_W  held instruction.
- occupancy  out  2  entries held (0..2).
- flush_cnt  out  16  count of flush cycles that discarded at least one entry.

Function
REQ-007 SHALL define accept = in_valid & in_ready and release = out_valid & out_ready.
REQ-008 SHALL hold state EMPTY, HALF (main entry valid) or FULL (main + skid entries valid); occupancy = 0/1/2 respectively.
REQ-009 SHALL drive out_valid = (state != EMPTY); out_* SHALL always come from the main entry.
REQ-010 SHALL, with SKID_EN=1, drive in_ready = (state != FULL) from registered state only (no combinational out_ready -> in_ready path).
REQ-011 SHALL, with SKID_EN=0, drive in_ready = !out_valid | out_ready; FULL SHALL be unreachable.
REQ-012 SHALL transition: EMPTY + accept -> HALF, main <= in.
REQ-013 SHALL transition: HALF + accept + !release -> FULL, skid <= in; HALF + accept + release -> HALF, main <= in; HALF + !accept + release -> EMPTY.
REQ-014 SHALL transition: FULL + release -> HALF, main <= skid; FULL + !release -> FULL, no change.
REQ-015 SHALL load the bubble (pc 0, pcplus4 0, instr NOP_INSTR) into main on every transition to EMPTY.
REQ-016 SHALL give 1-cycle latency from accept in EMPTY to out_valid, and sustain one transfer per cycle with out_ready held high.
REQ-017 SHALL treat flush as highest priority: next state EMPTY, main and skid <= bubble, any simultaneous accept discarded, release on that cycle still counts as consumed by downstream.
REQ-018 SHALL increment flush_cnt when flush=1 and state != EMPTY, saturating at 16'hFFFF.
REQ-019 SHALL hold all payload and state unchanged when neither accept, release nor flush occurs.
REQ-020 SHALL never drop or duplicate an accepted payload absent flush; order SHALL be FIFO.

Reset
REQ-021 SHALL, on reset=1 asynchronously: state EMPTY, main and skid = bubble, out_valid 0, occupancy 0, flush_cnt 0, in_ready 1.
REQ-022 SHALL, on reset asserted mid-operation (any state), discard all entries immediately; first accept after release of reset behaves as from EMPTY.

Verification
REQ-023 Single transfer: reset, in_valid=1 pc=0x00100 instr=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x00100, out_pcplus4=0x00104 passed through, out_instr=0x00500093; following cycle out_valid=0, out_instr=0x00000013.
REQ-024 Back-pressure: out_ready=0, push A then B -> occupancy 2, in_ready=0, out shows A; raise out_ready -> A then B on successive cycles, in_ready=1 after first release.
REQ-025 Flush while FULL: occupancy 2, flush=1 with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_instr=NOP, flush_cnt=1, new payload not held.
REQ-026 Flush saturation: force 65,540 flushes with state HALF -> flush_cnt=16'hFFFF; flush in EMPTY -> flush_cnt unchanged.
REQ-027 SKID_EN=0: out_ready=0 with out_valid=1 -> in_ready=0, occupancy never exceeds 1; out_ready=1 -> in_ready=1 same cycle, streaming 1/cycle.
REQ-028 Reset mid-stream: occupancy 2, assert reset between clock edges -> out_valid=0, occupancy 0, flush_cnt 0 immediately, before the next clk edge.
